// File: rtl/mult_issue_if.sv
// Decode-side handshake and multiply writeback signals of the multiply issue scheduler.
interface mult_issue_if;
  logic       kill_i;
  logic       dec_valid_i;
  logic       dec_is_mul_i;
  logic [4:0] dec_rd_i;
  logic       dec_rd_we_i;
  logic [4:0] dec_rs1_i;
  logic [4:0] dec_rs2_i;
  logic       dec_rs1_use_i;
  logic       dec_rs2_use_i;
  logic       stall_o;
  logic       mul_issue_o;
  logic       wb_mul_valid_o;
  logic [4:0] wb_mul_addr_o;
  logic       busy_o;
  logic [3:0] pending_cnt_o;

  modport master (
    output kill_i, dec_valid_i, dec_is_mul_i, dec_rd_i, dec_rd_we_i,
           dec_rs1_i, dec_rs2_i, dec_rs1_use_i, dec_rs2_use_i,
    input  stall_o, mul_issue_o, wb_mul_valid_o, wb_mul_addr_o, busy_o, pending_cnt_o
  );

  modport slave (
    input  kill_i, dec_valid_i, dec_is_mul_i, dec_rd_i, dec_rd_we_i,
           dec_rs1_i, dec_rs2_i, dec_rs1_use_i, dec_rs2_use_i,
    output stall_o, mul_issue_o, wb_mul_valid_o, wb_mul_addr_o, busy_o, pending_cnt_o
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Multiply issue scheduler: tracks in-flight multiplies in a fixed-latency shift register
// and stalls decode on RAW/WAW hazards and register-file write-port conflicts.
module mult_issue_ctrl #(
  parameter int STAGES  = 5,
  parameter int ALU_LAT = 2
) (
  input logic        clk_i,
  input logic        rst_i,
  mult_issue_if.slave bus
);
  // Entry that reaches writeback in the same cycle as a newly issued non-multiply
  localparam int SI = STAGES - 1 - ALU_LAT;

  logic [STAGES-1:0] ent_v;
  logic [STAGES-1:0] ent_we;
  logic [4:0]        ent_rd [STAGES];

  logic       raw, waw, strc, stall;
  logic [3:0] cnt;

  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (ent_v[k] && ent_we[k] && (ent_rd[k] != 5'd0)) begin
        if ((bus.dec_rs1_use_i && (bus.dec_rs1_i != 5'd0) && (bus.dec_rs1_i == ent_rd[k])) ||
            (bus.dec_rs2_use_i && (bus.dec_rs2_i != 5'd0) && (bus.dec_rs2_i == ent_rd[k])))
          raw = 1'b1;
        if (bus.dec_rd_we_i && (bus.dec_rd_i != 5'd0) && (bus.dec_rd_i == ent_rd[k]))
          waw = 1'b1;
      end
    end
    strc  = ~bus.dec_is_mul_i & bus.dec_rd_we_i & ent_v[SI] & ent_we[SI];
    stall = bus.dec_valid_i & (raw | waw | strc);
  end

  always_comb begin
    cnt = 4'd0;
    for (int k = 0; k < STAGES; k++)
      cnt = cnt + {3'd0, ent_v[k]};
  end

  assign bus.stall_o        = stall;
  assign bus.mul_issue_o    = bus.dec_valid_i & bus.dec_is_mul_i & ~stall & ~bus.kill_i;
  assign bus.wb_mul_valid_o = ent_v[STAGES-1] & ent_we[STAGES-1];
  assign bus.wb_mul_addr_o  = ent_rd[STAGES-1];
  assign bus.busy_o         = |ent_v;
  assign bus.pending_cnt_o  = cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_v  <= '0;
      ent_we <= '0;
      for (int k = 0; k < STAGES; k++) ent_rd[k] <= 5'd0;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        ent_v[k]  <= ent_v[k-1];
        ent_we[k] <= ent_we[k-1];
        ent_rd[k] <= ent_rd[k-1];
      end
      // Non-issuing cycles load a fully cleared entry so retired addresses read back as 0
      ent_v[0]  <= bus.mul_issue_o;
      ent_we[0] <= bus.mul_issue_o & bus.dec_rd_we_i;
      ent_rd[0] <= bus.mul_issue_o ? bus.dec_rd_i : 5'd0;
    end
  end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl using a time-indexed issue log as reference.
module tb_mult_issue_ctrl;
  localparam int S = 5;
  localparam int A = 2;
  localparam int LOGN = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mult_issue_if bus();

  mult_issue_ctrl #(.STAGES(S), .ALU_LAT(A)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: what was issued at each cycle, and the last cycle reset was sampled
  int   cyc = 0;
  int   rst_cyc = -1;
  bit   lv  [LOGN];
  bit   lwe [LOGN];
  logic [4:0] lrd [LOGN];

  function automatic bit in_flight(input int t);
    return (t >= 0) && (t > rst_cyc) && lv[t];
  endfunction

  function automatic bit m_live(input logic [4:0] r);
    for (int d = 1; d <= S; d++)
      if (in_flight(cyc - d) && lwe[cyc-d] && lrd[cyc-d] == r && r != 5'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    bit raw, waw, strc;
    int t;
    raw = (bus.dec_rs1_use_i && m_live(bus.dec_rs1_i)) || (bus.dec_rs2_use_i && m_live(bus.dec_rs2_i));
    waw = bus.dec_rd_we_i && m_live(bus.dec_rd_i);
    t = cyc - (S - A);
    strc = !bus.dec_is_mul_i && bus.dec_rd_we_i && in_flight(t) && lwe[t];
    return bus.dec_valid_i && (raw || waw || strc);
  endfunction

  function automatic bit m_issue();
    return bus.dec_valid_i && bus.dec_is_mul_i && !m_stall() && !bus.kill_i;
  endfunction

  function automatic bit m_wb_v();
    return in_flight(cyc - S) && lwe[cyc-S];
  endfunction

  function automatic logic [4:0] m_wb_a();
    return in_flight(cyc - S) ? lrd[cyc-S] : 5'd0;
  endfunction

  function automatic logic [3:0] m_cnt();
    logic [3:0] n = 4'd0;
    for (int d = 1; d <= S; d++) if (in_flight(cyc - d)) n = n + 4'd1;
    return n;
  endfunction

  task automatic set_dec(input bit v, input bit mul, input logic [4:0] rd, input bit we,
                         input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2);
    bus.dec_valid_i = v;   bus.dec_is_mul_i = mul; bus.dec_rd_i = rd; bus.dec_rd_we_i = we;
    bus.dec_rs1_i = rs1;   bus.dec_rs1_use_i = u1; bus.dec_rs2_i = rs2; bus.dec_rs2_use_i = u2;
    bus.kill_i = 1'b0;
    #1;
  endtask

  task automatic idle();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one cycle, recording the model's view of what issued
  task automatic tick();
    bit iss;
    iss = m_issue();
    @(posedge clk);
    if (rst) rst_cyc = cyc;
    lv[cyc] = iss; lwe[cyc] = bus.dec_rd_we_i; lrd[cyc] = bus.dec_rd_i;
    cyc++;
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < S + 1; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); rst = 1'b0; idle();
    checks++;
    if (bus.busy_o !== 1'b0 || bus.pending_cnt_o !== 4'd0 || bus.wb_mul_valid_o !== 1'b0 ||
        bus.wb_mul_addr_o !== 5'd0 || bus.stall_o !== 1'b0 || bus.mul_issue_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b cnt=%0d wbv=%b wba=%0d stall=%b iss=%b, expected all 0",
               bus.busy_o, bus.pending_cnt_o, bus.wb_mul_valid_o, bus.wb_mul_addr_o, bus.stall_o, bus.mul_issue_o);
    end
    set_dec(1, 1, 5, 1, 1, 1, 2, 1); tick();
    idle(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int rel = 3; rel <= 8; rel++) begin
      checks++;
      if (bus.pending_cnt_o !== 4'd0 || bus.busy_o !== 1'b0 || bus.wb_mul_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_midflight rel=%0d: cnt=%0d busy=%b wbv=%b, expected 0 0 0",
                 rel, bus.pending_cnt_o, bus.busy_o, bus.wb_mul_valid_o);
      end
      tick();
    end
  endtask

  task automatic test_latency();
    set_dec(1, 1, 5, 1, 0, 0, 0, 0);
    checks++;
    if (bus.mul_issue_o !== 1'b1) begin
      errors++; $display("FAIL latency_issue: mul_issue=%b expected 1", bus.mul_issue_o);
    end
    tick(); idle();
    for (int rel = 1; rel <= 7; rel++) begin
      checks++;
      if (bus.wb_mul_valid_o !== (rel == 5) || (rel == 5 && bus.wb_mul_addr_o !== 5'd5) ||
          bus.pending_cnt_o !== ((rel <= 5) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL latency rel=%0d: wbv=%b wba=%0d cnt=%0d, expected wbv=%b wba=5 cnt=%0d",
                 rel, bus.wb_mul_valid_o, bus.wb_mul_addr_o, bus.pending_cnt_o, rel == 5, (rel <= 5));
      end
      tick();
    end
  endtask

  task automatic test_raw();
    set_dec(1, 1, 5, 1, 0, 0, 0, 0); tick();
    for (int rel = 1; rel <= 6; rel++) begin
      set_dec(1, 0, 10, 1, 5, 1, 0, 0);
      checks++;
      if (bus.stall_o !== (rel <= 5)) begin
        errors++; $display("FAIL raw_rs1 rel=%0d: stall=%b expected %b", rel, bus.stall_o, rel <= 5);
      end
      tick();
    end
    drain();
    set_dec(1, 1, 5, 1, 0, 0, 0, 0); tick();
    set_dec(1, 0, 11, 1, 1, 1, 5, 0);
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL raw_unused_rs2: stall=%b expected 0", bus.stall_o);
    end
    tick(); drain();
  endtask

  task automatic test_struct();
    for (int pass = 0; pass < 2; pass++) begin
      set_dec(1, 1, 7, 1, 0, 0, 0, 0); tick();
      idle(); tick(); tick();
      if (pass == 0) set_dec(1, 0, 9, 1, 1, 1, 2, 1);
      else           set_dec(1, 0, 0, 0, 1, 1, 2, 1);
      checks++;
      if (bus.stall_o !== (pass == 0)) begin
        errors++; $display("FAIL struct pass=%0d rel=3: stall=%b expected %b", pass, bus.stall_o, pass == 0);
      end
      tick();
      if (pass == 0) begin
        set_dec(1, 0, 9, 1, 1, 1, 2, 1);
        checks++;
        if (bus.stall_o !== 1'b0) begin
          errors++; $display("FAIL struct rel=4: stall=%b expected 0", bus.stall_o);
        end
        tick();
      end
      drain();
    end
  endtask

  task automatic test_x0_waw();
    set_dec(1, 1, 0, 1, 0, 0, 0, 0); tick();
    set_dec(1, 0, 3, 1, 0, 1, 0, 1);
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL x0_src: stall=%b expected 0", bus.stall_o);
    end
    tick(); drain();
    set_dec(1, 1, 6, 1, 0, 0, 0, 0); tick();
    for (int rel = 1; rel <= 6; rel++) begin
      set_dec(1, 0, 6, 1, 1, 1, 2, 1);
      checks++;
      if (bus.stall_o !== (rel <= 5)) begin
        errors++; $display("FAIL waw rel=%0d: stall=%b expected %b", rel, bus.stall_o, rel <= 5);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int rel = 0; rel < 5; rel++) begin
      set_dec(1, 1, 5'(rel + 1), 1, 0, 0, 0, 0);
      checks++;
      if (bus.mul_issue_o !== 1'b1 || bus.stall_o !== 1'b0) begin
        errors++; $display("FAIL b2b_issue rel=%0d: iss=%b stall=%b expected 1 0", rel, bus.mul_issue_o, bus.stall_o);
      end
      tick();
    end
    for (int rel = 5; rel <= 10; rel++) begin
      if (rel == 5) begin
        set_dec(1, 1, 8, 1, 0, 0, 0, 0);
        bus.kill_i = 1'b1; #1;
        checks++;
        if (bus.mul_issue_o !== 1'b0 || bus.pending_cnt_o !== 4'd5) begin
          errors++; $display("FAIL kill rel=5: iss=%b cnt=%0d expected 0 5", bus.mul_issue_o, bus.pending_cnt_o);
        end
      end else idle();
      checks++;
      if (bus.wb_mul_valid_o !== (rel <= 9) || (rel <= 9 && bus.wb_mul_addr_o !== 5'(rel - 4))) begin
        errors++;
        $display("FAIL b2b_wb rel=%0d: wbv=%b wba=%0d expected %b %0d",
                 rel, bus.wb_mul_valid_o, bus.wb_mul_addr_o, rel <= 9, rel - 4);
      end
      if (rel == 6) begin
        checks++;
        if (bus.pending_cnt_o !== 4'd4) begin
          errors++; $display("FAIL kill_cnt rel=6: cnt=%0d expected 4", bus.pending_cnt_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      set_dec($urandom_range(0, 9) < 8, $urandom_range(0, 1), 5'($urandom_range(0, 3)),
              $urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), $urandom_range(0, 1),
              5'($urandom_range(0, 3)), $urandom_range(0, 1));
      bus.kill_i = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      checks++;
      if (bus.stall_o !== m_stall() || bus.mul_issue_o !== m_issue() ||
          bus.wb_mul_valid_o !== m_wb_v() || bus.wb_mul_addr_o !== m_wb_a() ||
          bus.busy_o !== (m_cnt() != 4'd0) || bus.pending_cnt_o !== m_cnt()) begin
        errors++;
        $display("FAIL random cyc=%0d: stall=%b/%b iss=%b/%b wbv=%b/%b wba=%0d/%0d busy=%b cnt=%0d/%0d (got/expected)",
                 cyc, bus.stall_o, m_stall(), bus.mul_issue_o, m_issue(), bus.wb_mul_valid_o, m_wb_v(),
                 bus.wb_mul_addr_o, m_wb_a(), bus.busy_o, bus.pending_cnt_o, m_cnt());
      end
      tick();
      rst = 1'b0;
    end
  endtask

  initial begin
    idle();
    test_reset();
    drain();
    test_latency();
    drain();
    test_raw();
    test_struct();
    test_x0_waw();
    test_back_to_back();
    drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
